ramp_soft_start_ctrl: RTL and testbench

Parametrised soft-start motor ramp controller: steps an output speed level up through `NUM_STEPS` discrete levels and back down. Each step is held for a programmable dwell, with separate fast and slow dwells. It adds controlled ramp-down, re-ramp from mid-descent, emergency stop with a sticky fault, and a run-enable freeze. It sits behind the chip top-level, driven from `ui_in` control bits, with its level outputs mapped onto `uo_out`.

---
 rtl/ramp_pkg.sv | 22 ++
 rtl/ramp_tick_gen.sv | 32 +++
 rtl/ramp_soft_start_ctrl.sv | 137 +++++++++++++
 tb/tb_ramp_soft_start_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramp_pkg.sv
// Shared types and width helpers for the soft-start ramp controller.
package ramp_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_t;

  // Counter widths never drop below one bit, even for a modulus of 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Dwell prescaler: emits one tick every PRESC_DIV enabled clock cycles.
module ramp_tick_gen
  import ramp_pkg::*;
#(
  parameter int PRESC_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  output logic tick
);

  localparam int PW = clog2_min1(PRESC_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc_cnt;

  assign tick = ena && (presc_cnt == PRESC_LAST);

  // clr wins over ena so an emergency stop restarts the prescaler even while frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (clr || tick) begin
      presc_cnt <= '0;
    end else if (ena) begin
      presc_cnt <= presc_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/ramp_soft_start_ctrl.sv
// Soft-start motor ramp controller: steps a speed level up to NUM_STEPS and back
// down with a programmable per-step dwell, emergency stop and run-enable freeze.
module ramp_soft_start_ctrl
  import ramp_pkg::*;
#(
  parameter int NUM_STEPS  = 3,
  parameter int PRESC_DIV  = 4,
  parameter int DWELL_FAST = 2,
  parameter int DWELL_SLOW = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  input  logic                               start,
  input  logic                               stop,
  input  logic                               estop,
  input  logic                               mode,
  output logic [NUM_STEPS-1:0]               step_oh,
  output logic [$clog2(NUM_STEPS+1)-1:0]     level,
  output logic                               busy,
  output logic                               at_speed,
  output logic                               done,
  output logic                               fault
);

  localparam int LW = $clog2(NUM_STEPS + 1);
  localparam int DW = clog2_min1(max2(DWELL_FAST, DWELL_SLOW));
  localparam logic [LW-1:0] TOP_LEVEL = LW'(NUM_STEPS);
  localparam logic [DW-1:0] FAST_LAST = DW'(DWELL_FAST - 1);
  localparam logic [DW-1:0] SLOW_LAST = DW'(DWELL_SLOW - 1);

  ramp_state_t   state, state_n;
  logic [LW-1:0] level_n;
  logic          mode_r, mode_n;
  logic          fault_n, done_n;
  logic          tick, expire, clr;
  logic [DW-1:0] dwell_cnt;

  ramp_tick_gen #(.PRESC_DIV(PRESC_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (clr),
    .tick  (tick)
  );

  assign expire = tick && (dwell_cnt == (mode_r ? FAST_LAST : SLOW_LAST));

  // Priority is estop > stop > start > dwell expiry; everything but estop waits on ena.
  always_comb begin
    state_n = state;
    level_n = level;
    mode_n  = mode_r;
    fault_n = fault;
    done_n  = 1'b0;
    if (estop) begin
      state_n = IDLE;
      level_n = '0;
      fault_n = 1'b1;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state_n = RAMP_UP;
            level_n = LW'(1);
            mode_n  = mode;
            fault_n = 1'b0;
          end
        end
        RAMP_UP: begin
          if (stop) begin
            state_n = RAMP_DOWN;
          end else if (expire) begin
            level_n = level + LW'(1);
            if (level_n == TOP_LEVEL) state_n = RUN;
          end
        end
        RUN: begin
          if (stop) state_n = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (start && !stop) begin
            // Re-ramp from the top level has nowhere to climb, so it lands straight in RUN.
            mode_n  = mode;
            state_n = (level == TOP_LEVEL) ? RUN : RAMP_UP;
          end else if (expire) begin
            level_n = level - LW'(1);
            if (level_n == '0) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign clr = estop || (state_n != state) || (level_n != level);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      level  <= '0;
      mode_r <= 1'b0;
      fault  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      mode_r <= mode_n;
      fault  <= fault_n;
      done   <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
    end else if (clr || expire) begin
      dwell_cnt <= '0;
    end else if (tick) begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  always_comb begin
    step_oh = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      step_oh[i] = (level == LW'(i + 1));
    end
  end

  assign busy     = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign at_speed = (state == RUN);

endmodule

// File: tb/tb_ramp_soft_start_ctrl.sv
// Self-checking bench for ramp_soft_start_ctrl: directed timeline tests plus a
// randomized run against a cycle-counting behavioural model.
module tb_ramp_soft_start_ctrl;

  localparam int NUM_STEPS  = 3;
  localparam int PRESC_DIV  = 4;
  localparam int DWELL_FAST = 2;
  localparam int DWELL_SLOW = 5;
  localparam int LW = $clog2(NUM_STEPS + 1);
  localparam int VW = LW + NUM_STEPS + 4;

  localparam int M_IDLE = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0, ena = 1'b1, start = 1'b0, stop = 1'b0, estop = 1'b0, mode = 1'b1;
  logic [NUM_STEPS-1:0] step_oh;
  logic [LW-1:0]        level;
  logic                 busy, at_speed, done, fault;

  int tests_run = 0;
  int tests_failed = 0;

  int m_state = M_IDLE, m_level = 0, m_elapsed = 0;
  bit m_fast = 1'b0, m_fault = 1'b0, m_done = 1'b0;

  ramp_soft_start_ctrl #(
    .NUM_STEPS(NUM_STEPS), .PRESC_DIV(PRESC_DIV),
    .DWELL_FAST(DWELL_FAST), .DWELL_SLOW(DWELL_SLOW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
    .estop(estop), .mode(mode), .step_oh(step_oh), .level(level),
    .busy(busy), .at_speed(at_speed), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  // Model counts enabled cycles spent on the current step; a step lasts dwell*PRESC_DIV of them.
  task automatic model_update();
    int len;
    len = (m_fast ? DWELL_FAST : DWELL_SLOW) * PRESC_DIV;
    m_done = 1'b0;
    if (!rst_n) begin
      m_state = M_IDLE; m_level = 0; m_elapsed = 0; m_fast = 1'b0; m_fault = 1'b0;
    end else if (estop) begin
      m_state = M_IDLE; m_level = 0; m_elapsed = 0; m_fault = 1'b1;
    end else if (ena) begin
      case (m_state)
        M_IDLE: if (start && !stop) begin
          m_state = M_UP; m_level = 1; m_elapsed = 0; m_fast = mode; m_fault = 1'b0;
        end
        M_UP: if (stop) begin
          m_state = M_DOWN; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == len) begin
            m_level++; m_elapsed = 0;
            if (m_level == NUM_STEPS) m_state = M_RUN;
          end
        end
        M_RUN: if (stop) begin
          m_state = M_DOWN; m_elapsed = 0;
        end
        default: if (start && !stop) begin
          m_fast = mode; m_elapsed = 0;
          m_state = (m_level == NUM_STEPS) ? M_RUN : M_UP;
        end else begin
          m_elapsed++;
          if (m_elapsed == len) begin
            m_level--; m_elapsed = 0;
            if (m_level == 0) begin
              m_state = M_IDLE; m_done = 1'b1;
            end
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; estop = 1'b0; ena = 1'b1;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic go_run_fast();
    do_reset();
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (16) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; mode = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({level, step_oh, busy, at_speed, done, fault} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: level=%0d step_oh=%b busy=%b at_speed=%b done=%b fault=%b, want all 0",
               level, step_oh, busy, at_speed, done, fault);
    end
    rst_n = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if (level !== LW'(1) || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: level=%0d busy=%b, want level=1 busy=1", level, busy);
    end
  endtask

  task automatic test_fast_ramp();
    int exp_level;
    do_reset();
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 17; c++) begin
      step();
      exp_level = (c < 9) ? 1 : (c < 17) ? 2 : 3;
      tests_run++;
      if (level !== LW'(exp_level) || at_speed !== (c == 17)) begin
        tests_failed++;
        $display("[TB] FAIL fast_ramp cycle %0d: level=%0d at_speed=%b, want level=%0d at_speed=%b",
                 c, level, at_speed, exp_level, (c == 17));
      end
    end
    tests_run++;
    if (step_oh !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL fast_ramp_step_oh: got %b want 100", step_oh);
    end
  endtask

  task automatic test_slow_ramp();
    int exp_level;
    do_reset();
    mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    mode = 1'b1;
    for (int c = 2; c <= 41; c++) begin
      step();
      exp_level = (c < 21) ? 1 : (c < 41) ? 2 : 3;
      tests_run++;
      if (level !== LW'(exp_level) || at_speed !== (c == 41)) begin
        tests_failed++;
        $display("[TB] FAIL slow_ramp cycle %0d: level=%0d at_speed=%b, want level=%0d at_speed=%b",
                 c, level, at_speed, exp_level, (c == 41));
      end
    end
  endtask

  task automatic test_ramp_down();
    int exp_level;
    go_run_fast();
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || at_speed !== 1'b0 || level !== LW'(3)) begin
      tests_failed++;
      $display("[TB] FAIL ramp_down_enter: busy=%b at_speed=%b level=%0d, want 1 0 3", busy, at_speed, level);
    end
    for (int off = 2; off <= 26; off++) begin
      step();
      exp_level = (off < 9) ? 3 : (off < 17) ? 2 : (off < 25) ? 1 : 0;
      tests_run++;
      if (level !== LW'(exp_level) || done !== (off == 25)) begin
        tests_failed++;
        $display("[TB] FAIL ramp_down offset %0d: level=%0d done=%b, want level=%0d done=%b",
                 off, level, done, exp_level, (off == 25));
      end
    end
    tests_run++;
    if (busy !== 1'b0 || at_speed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ramp_down_idle: busy=%b at_speed=%b, want 0 0", busy, at_speed);
    end
  endtask

  task automatic test_reramp();
    go_run_fast();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (8) step();
    start = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if (level !== LW'(2) || busy !== 1'b1 || at_speed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reramp_enter: level=%0d busy=%b at_speed=%b, want 2 1 0", level, busy, at_speed);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      tests_run++;
      if (at_speed !== (k == 8)) begin
        tests_failed++;
        $display("[TB] FAIL reramp_at_speed k=%0d: got %b want %b", k, at_speed, (k == 8));
      end
    end
  endtask

  task automatic test_estop();
    do_reset();
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    estop = 1'b1;
    step();
    tests_run++;
    if (level !== '0 || fault !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL estop_hit: level=%0d fault=%b done=%b busy=%b, want 0 1 0 0", level, fault, done, busy);
    end
    start = 1'b1;
    repeat (3) step();
    tests_run++;
    if (level !== '0 || fault !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL estop_start_ignored: level=%0d fault=%b busy=%b, want 0 1 0", level, fault, busy);
    end
    estop = 1'b0;
    step();
    start = 1'b0;
    tests_run++;
    if (level !== LW'(1) || fault !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL estop_restart: level=%0d fault=%b, want 1 0", level, fault);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    ena = 1'b0;
    repeat (10) step();
    ena = 1'b1;
    repeat (4) step();
    tests_run++;
    if (level !== LW'(1)) begin
      tests_failed++;
      $display("[TB] FAIL freeze_hold: level=%0d at cycle 18, want 1", level);
    end
    step();
    tests_run++;
    if (level !== LW'(2)) begin
      tests_failed++;
      $display("[TB] FAIL freeze_step: level=%0d at cycle 19, want 2", level);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    start = 1'b1; stop = 1'b1;
    repeat (5) step();
    start = 1'b0; stop = 1'b0;
    tests_run++;
    if (level !== '0 || busy !== 1'b0 || at_speed !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL conflict_idle: level=%0d busy=%b at_speed=%b, want 0 0 0", level, busy, at_speed);
    end
  endtask

  task automatic test_random();
    logic [NUM_STEPS-1:0] exp_oh;
    logic [VW-1:0] exp_vec, got_vec;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      estop = ($urandom_range(0, 79) == 0);
      ena   = ($urandom_range(0, 7) != 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      mode  = $urandom_range(0, 1);
      step();
      exp_oh = '0;
      if (m_level > 0) exp_oh[m_level-1] = 1'b1;
      exp_vec = {LW'(m_level), exp_oh, (m_state == M_UP || m_state == M_DOWN),
                 (m_state == M_RUN), m_done, m_fault};
      got_vec = {level, step_oh, busy, at_speed, done, fault};
      tests_run++;
      if (got_vec !== exp_vec) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d: {level,step_oh,busy,at_speed,done,fault}=%b, want %b",
                 i, got_vec, exp_vec);
      end
    end
    rst_n = 1'b1; estop = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fast_ramp();
    test_slow_ramp();
    test_ramp_down();
    test_reramp();
    test_estop();
    test_freeze();
    test_conflict();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
